// File: rtl/biu_pkg.sv
// Shared definitions for the BIU cache-line arbiter: FSM encodings,
// requester ids and line-offset helpers.
package biu_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   localparam logic REQ_IC = 1'b0;
   localparam logic REQ_DC = 1'b1;

   localparam int unsigned LINE_W_DEFAULT = 512;

   // Number of byte-offset bits inside one cache line.
   function automatic int unsigned line_offset_w(input int unsigned line_w);
      return $clog2(line_w / 8);
   endfunction

   localparam int unsigned LINE_OFFSET_W = line_offset_w(LINE_W_DEFAULT);

endpackage

// File: rtl/biu_arb_picker.sv
// Two-input grant logic for the BIU line arbiter.
// BIU_ARB_RR_EN selects round-robin; otherwise dcache has fixed priority.
module biu_arb_picker
   import biu_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ic_vld_i,
   input  logic dc_vld_i,
   input  logic accept_i,
   output logic gnt_ic_o,
   output logic gnt_dc_o
);

`ifdef BIU_ARB_RR_EN
   logic ptr_q;
   logic ptr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= REQ_DC;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // The pointer breaks ties only; a lone requester always wins.
   always_comb begin
      gnt_ic_o = 1'b0;
      gnt_dc_o = 1'b0;
      if (ic_vld_i && dc_vld_i) begin
         gnt_dc_o = (ptr_q == REQ_DC);
         gnt_ic_o = (ptr_q == REQ_IC);
      end else begin
         gnt_dc_o = dc_vld_i;
         gnt_ic_o = ic_vld_i;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept_i) begin
         ptr_d = gnt_dc_o ? REQ_IC : REQ_DC;
      end
   end
`else
   logic unused_rr;
   assign unused_rr = &{1'b0, clk, rst_n, accept_i};

   always_comb begin
      gnt_dc_o = dc_vld_i;
      gnt_ic_o = ic_vld_i && !dc_vld_i;
   end
`endif

endmodule

// File: rtl/biu_line_arbiter.sv
// Shares the single BIU cache-line channel between icache and dcache,
// one outstanding transaction at a time. Optional macro: BIU_ARB_RR_EN.
module biu_line_arbiter
   import biu_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned LINE_W = 512
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              ic_req_vld_i,
   output logic              ic_req_rdy_o,
   input  logic [ADDR_W-1:0] ic_req_addr_i,
   output logic              ic_resp_vld_o,
   input  logic              ic_resp_rdy_i,
   output logic [LINE_W-1:0] ic_resp_rdata_o,
   output logic              ic_resp_err_o,

   input  logic              dc_req_vld_i,
   output logic              dc_req_rdy_o,
   input  logic              dc_req_rd_i,
   input  logic [ADDR_W-1:0] dc_req_addr_i,
   input  logic [LINE_W-1:0] dc_req_wdata_i,
   output logic              dc_resp_vld_o,
   input  logic              dc_resp_rdy_i,
   output logic [LINE_W-1:0] dc_resp_rdata_o,
   output logic              dc_resp_err_o,

   output logic              cache_req_vld_o,
   input  logic              cache_req_rdy_i,
   output logic              cache_req_rd_o,
   output logic [ADDR_W-1:0] cache_req_addr_o,
   output logic [LINE_W-1:0] cache_req_wdata_o,
   input  logic              cache_resp_vld_i,
   output logic              cache_resp_rdy_o,
   input  logic [LINE_W-1:0] cache_resp_rdata_i,
   input  logic              cache_resp_err_i
);

   localparam int unsigned OFF_W = line_offset_w(LINE_W);
   localparam logic [ADDR_W-1:0] LINE_MASK =
      ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   state_t              state_q,    state_d;
   logic                owner_q,    owner_d;
   logic                rd_q,       rd_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [LINE_W-1:0]   wdata_q,    wdata_d;
   logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
   logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
   logic                ic_err_q,   ic_err_d;
   logic                dc_err_q,   dc_err_d;
   logic                req_vld_q,  req_vld_d;
   logic                resp_rdy_q, resp_rdy_d;
   logic                ic_vld_q,   ic_vld_d;
   logic                dc_vld_q,   dc_vld_d;

   logic                gnt_ic_c;
   logic                gnt_dc_c;
   logic                idle_c;
   logic                accept_c;
   logic                owner_rdy_c;
   logic [ADDR_W-1:0]   addr_sel_c;

   biu_arb_picker u_picker (
      .clk      (clk),
      .rst_n    (rst_n),
      .ic_vld_i (ic_req_vld_i),
      .dc_vld_i (dc_req_vld_i),
      .accept_i (accept_c),
      .gnt_ic_o (gnt_ic_c),
      .gnt_dc_o (gnt_dc_c)
   );

   // Requests are only offered while idle and out of reset.
   assign idle_c       = rst_n && (state_q == ST_IDLE);
   assign ic_req_rdy_o = idle_c && gnt_ic_c;
   assign dc_req_rdy_o = idle_c && gnt_dc_c;
   assign accept_c     = (ic_req_vld_i && ic_req_rdy_o) ||
                         (dc_req_vld_i && dc_req_rdy_o);
   assign addr_sel_c   = gnt_dc_c ? dc_req_addr_i : ic_req_addr_i;
   assign owner_rdy_c  = (owner_q == REQ_DC) ? dc_resp_rdy_i : ic_resp_rdy_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= REQ_IC;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
         ic_err_q   <= 1'b0;
         dc_err_q   <= 1'b0;
         req_vld_q  <= 1'b0;
         resp_rdy_q <= 1'b0;
         ic_vld_q   <= 1'b0;
         dc_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ic_rdata_q <= ic_rdata_d;
         dc_rdata_q <= dc_rdata_d;
         ic_err_q   <= ic_err_d;
         dc_err_q   <= dc_err_d;
         req_vld_q  <= req_vld_d;
         resp_rdy_q <= resp_rdy_d;
         ic_vld_q   <= ic_vld_d;
         dc_vld_q   <= dc_vld_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ic_rdata_d = ic_rdata_q;
      dc_rdata_d = dc_rdata_q;
      ic_err_d   = ic_err_q;
      dc_err_d   = dc_err_q;

      case (state_q)
         ST_IDLE: begin
            // Icache refills go out as reads with zero write data.
            if (accept_c) begin
               owner_d = gnt_dc_c ? REQ_DC : REQ_IC;
               rd_d    = gnt_dc_c ? dc_req_rd_i : 1'b1;
               addr_d  = addr_sel_c & LINE_MASK;
               wdata_d = gnt_dc_c ? dc_req_wdata_i : {LINE_W{1'b0}};
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cache_req_rdy_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cache_resp_vld_i) begin
               if (owner_q == REQ_DC) begin
                  dc_rdata_d = cache_resp_rdata_i;
                  dc_err_d   = cache_resp_err_i;
               end else begin
                  ic_rdata_d = cache_resp_rdata_i;
                  ic_err_d   = cache_resp_err_i;
               end
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (owner_rdy_c) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      // Handshake outputs are decoded from the next state and registered.
      req_vld_d  = (state_d == ST_ISSUE);
      resp_rdy_d = (state_d == ST_WAIT);
      ic_vld_d   = (state_d == ST_RESP) && (owner_d == REQ_IC);
      dc_vld_d   = (state_d == ST_RESP) && (owner_d == REQ_DC);
   end

   assign cache_req_vld_o   = req_vld_q;
   assign cache_req_rd_o    = rd_q;
   assign cache_req_addr_o  = addr_q;
   assign cache_req_wdata_o = wdata_q;
   assign cache_resp_rdy_o  = resp_rdy_q;

   assign ic_resp_vld_o     = ic_vld_q;
   assign ic_resp_rdata_o   = ic_rdata_q;
   assign ic_resp_err_o     = ic_err_q;
   assign dc_resp_vld_o     = dc_vld_q;
   assign dc_resp_rdata_o   = dc_rdata_q;
   assign dc_resp_err_o     = dc_err_q;

endmodule

// File: tb/tb_biu_line_arbiter.sv
// Self-checking bench for biu_line_arbiter: vector table plus scoreboard,
// with hand-written arbitration, stall and reset sequences.
module tb_biu_line_arbiter;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned LINE_W = 512;

   logic              clk;
   logic              rst_n;
   logic              ic_req_vld_i;
   logic              ic_req_rdy_o;
   logic [ADDR_W-1:0] ic_req_addr_i;
   logic              ic_resp_vld_o;
   logic              ic_resp_rdy_i;
   logic [LINE_W-1:0] ic_resp_rdata_o;
   logic              ic_resp_err_o;
   logic              dc_req_vld_i;
   logic              dc_req_rdy_o;
   logic              dc_req_rd_i;
   logic [ADDR_W-1:0] dc_req_addr_i;
   logic [LINE_W-1:0] dc_req_wdata_i;
   logic              dc_resp_vld_o;
   logic              dc_resp_rdy_i;
   logic [LINE_W-1:0] dc_resp_rdata_o;
   logic              dc_resp_err_o;
   logic              cache_req_vld_o;
   logic              cache_req_rdy_i;
   logic              cache_req_rd_o;
   logic [ADDR_W-1:0] cache_req_addr_o;
   logic [LINE_W-1:0] cache_req_wdata_o;
   logic              cache_resp_vld_i;
   logic              cache_resp_rdy_o;
   logic [LINE_W-1:0] cache_resp_rdata_i;
   logic              cache_resp_err_i;

   int n_chk;
   int n_pass;

   typedef struct {
      logic              owner_dc;
      logic [LINE_W-1:0] rdata;
      logic              err;
   } exp_t;

   typedef struct {
      logic              is_dc;
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] rdata;
      logic              err;
      int                req_stall;
      int                resp_stall;
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_rd;
      logic [LINE_W-1:0] exp_wdata;
   } vec_t;

   exp_t              exp_q[$];
   vec_t              vecs[5];
   logic [LINE_W-1:0] last_ic_rdata;

   biu_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ic_req_vld_i      (ic_req_vld_i),
      .ic_req_rdy_o      (ic_req_rdy_o),
      .ic_req_addr_i     (ic_req_addr_i),
      .ic_resp_vld_o     (ic_resp_vld_o),
      .ic_resp_rdy_i     (ic_resp_rdy_i),
      .ic_resp_rdata_o   (ic_resp_rdata_o),
      .ic_resp_err_o     (ic_resp_err_o),
      .dc_req_vld_i      (dc_req_vld_i),
      .dc_req_rdy_o      (dc_req_rdy_o),
      .dc_req_rd_i       (dc_req_rd_i),
      .dc_req_addr_i     (dc_req_addr_i),
      .dc_req_wdata_i    (dc_req_wdata_i),
      .dc_resp_vld_o     (dc_resp_vld_o),
      .dc_resp_rdy_i     (dc_resp_rdy_i),
      .dc_resp_rdata_o   (dc_resp_rdata_o),
      .dc_resp_err_o     (dc_resp_err_o),
      .cache_req_vld_o   (cache_req_vld_o),
      .cache_req_rdy_i   (cache_req_rdy_i),
      .cache_req_rd_o    (cache_req_rd_o),
      .cache_req_addr_o  (cache_req_addr_o),
      .cache_req_wdata_o (cache_req_wdata_o),
      .cache_resp_vld_i  (cache_resp_vld_i),
      .cache_resp_rdy_o  (cache_resp_rdy_o),
      .cache_resp_rdata_i(cache_resp_rdata_i),
      .cache_resp_err_i  (cache_resp_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chka(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_ic_req_rdy"},    ic_req_rdy_o,      1'b0);
      chk1({tag, "_dc_req_rdy"},    dc_req_rdy_o,      1'b0);
      chk1({tag, "_ic_resp_vld"},   ic_resp_vld_o,     1'b0);
      chk1({tag, "_dc_resp_vld"},   dc_resp_vld_o,     1'b0);
      chk1({tag, "_ic_err"},        ic_resp_err_o,     1'b0);
      chk1({tag, "_dc_err"},        dc_resp_err_o,     1'b0);
      chkw({tag, "_ic_rdata"},      ic_resp_rdata_o,   '0);
      chkw({tag, "_dc_rdata"},      dc_resp_rdata_o,   '0);
      chk1({tag, "_cache_req_vld"}, cache_req_vld_o,   1'b0);
      chk1({tag, "_cache_req_rd"},  cache_req_rd_o,    1'b0);
      chka({tag, "_cache_addr"},    cache_req_addr_o,  '0);
      chkw({tag, "_cache_wdata"},   cache_req_wdata_o, '0);
      chk1({tag, "_cache_resp_rdy"}, cache_resp_rdy_o, 1'b0);
   endtask

   // Entered at the negedge right after the accepting posedge.
   task automatic finish_txn(input logic own_dc, input logic [ADDR_W-1:0] ea, input logic erd,
                             input logic [LINE_W-1:0] ewd, input logic [LINE_W-1:0] rdata,
                             input logic err, input int rstall, input int pstall, input logic poke);
      int   lat;
      exp_t e;
      chk1("req_vld_at_n1", cache_req_vld_o, 1'b1);
      chka("req_addr", cache_req_addr_o, ea);
      chk1("req_rd", cache_req_rd_o, erd);
      chkw("req_wdata", cache_req_wdata_o, ewd);
      if (poke) begin
         if (own_dc) ic_req_vld_i = 1'b1;
         else dc_req_vld_i = 1'b1;
      end
      for (int i = 0; i < rstall; i++) begin
         ic_req_addr_i  = {$urandom, $urandom};
         dc_req_addr_i  = {$urandom, $urandom};
         dc_req_wdata_i = {16{$urandom}};
         #1;
         chk1("stall_req_vld", cache_req_vld_o, 1'b1);
         chka("stall_addr", cache_req_addr_o, ea);
         chk1("stall_rd", cache_req_rd_o, erd);
         chkw("stall_wdata", cache_req_wdata_o, ewd);
         chk1("stall_req_rdy", ic_req_rdy_o | dc_req_rdy_o, 1'b0);
         @(negedge clk);
      end
      cache_req_rdy_i = 1'b1;
      @(negedge clk);
      cache_req_rdy_i = 1'b0;
      chk1("wait_req_vld", cache_req_vld_o, 1'b0);
      chk1("wait_resp_rdy", cache_resp_rdy_o, 1'b1);
      cache_resp_vld_i   = 1'b1;
      cache_resp_rdata_i = rdata;
      cache_resp_err_i   = err;
      @(negedge clk);
      cache_resp_vld_i   = 1'b0;
      cache_resp_rdata_i = {16{$urandom}};
      cache_resp_err_i   = ~err;
      lat = 0;
      while (((own_dc ? dc_resp_vld_o : ic_resp_vld_o) !== 1'b1) && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      chka("resp_latency", 64'(lat), 64'd0);
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL scoreboard: got response expected none queued");
      end else begin
         e = exp_q.pop_front();
         chk1("resp_vld_dc", dc_resp_vld_o, e.owner_dc);
         chk1("resp_vld_ic", ic_resp_vld_o, !e.owner_dc);
         if (e.owner_dc) begin
            if (erd) chkw("dc_rdata", dc_resp_rdata_o, e.rdata);
            chk1("dc_err", dc_resp_err_o, e.err);
            chkw("ic_rdata_hold", ic_resp_rdata_o, last_ic_rdata);
         end else begin
            chkw("ic_rdata", ic_resp_rdata_o, e.rdata);
            chk1("ic_err", ic_resp_err_o, e.err);
         end
      end
      chk1("resp_cache_rdy_low", cache_resp_rdy_o, 1'b0);
      for (int i = 0; i < pstall; i++) begin
         @(negedge clk);
         chk1("pstall_resp_vld", own_dc ? dc_resp_vld_o : ic_resp_vld_o, 1'b1);
         chk1("pstall_req_rdy", ic_req_rdy_o | dc_req_rdy_o, 1'b0);
      end
      if (own_dc) dc_resp_rdy_i = 1'b1;
      else ic_resp_rdy_i = 1'b1;
      if (poke) begin
         #1;
         chk1("resp_hs_req_rdy", ic_req_rdy_o | dc_req_rdy_o, 1'b0);
         ic_req_vld_i = 1'b0;
         dc_req_vld_i = 1'b0;
      end
      @(negedge clk);
      ic_resp_rdy_i = 1'b0;
      dc_resp_rdy_i = 1'b0;
      chk1("resp_vld_drop", ic_resp_vld_o | dc_resp_vld_o, 1'b0);
      if (!own_dc) last_ic_rdata = rdata;
   endtask

   task automatic run_txn(input vec_t v);
      exp_t e;
      dc_req_wdata_i = v.wdata;
      dc_req_rd_i    = v.rd;
      if (v.is_dc) begin
         dc_req_vld_i  = 1'b1;
         dc_req_addr_i = v.addr;
      end else begin
         ic_req_vld_i  = 1'b1;
         ic_req_addr_i = v.addr;
      end
      #1;
      chk1("req_rdy_owner", v.is_dc ? dc_req_rdy_o : ic_req_rdy_o, 1'b1);
      chk1("req_rdy_other", v.is_dc ? ic_req_rdy_o : dc_req_rdy_o, 1'b0);
      e.owner_dc = v.is_dc;
      e.rdata    = v.rdata;
      e.err      = v.err;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      ic_req_vld_i = 1'b0;
      dc_req_vld_i = 1'b0;
      finish_txn(v.is_dc, v.exp_addr, v.exp_rd, v.exp_wdata, v.rdata, v.err,
                 v.req_stall, v.resp_stall, v.req_stall > 0);
   endtask

   initial begin
      logic [LINE_W-1:0] incr;
      logic [LINE_W-1:0] arb_wd;
      logic [LINE_W-1:0] arb_rd;
      logic              exp_dc;
      exp_t              e;

      n_chk = 0;
      n_pass = 0;
      last_ic_rdata = '0;
      for (int b = 0; b < 64; b++) incr[b*8 +: 8] = 8'(b);

      vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0047, {16{32'hDEAD_BEEF}}, {64{8'hA5}}, 1'b0,
                 0, 0, 64'h0000_0000_8000_0040, 1'b1, '0};
      vecs[1] = '{1'b1, 1'b0, 64'h0000_0000_0000_1000, incr, {16{32'h0BAD_F00D}}, 1'b1,
                 0, 0, 64'h0000_0000_0000_1000, 1'b0, incr};
      vecs[2] = '{1'b1, 1'b1, 64'h0000_1234_5678_9ABF, {64{8'h3C}}, {8{64'h0123_4567_89AB_CDEF}}, 1'b0,
                 0, 0, 64'h0000_1234_5678_9A80, 1'b1, {64{8'h3C}}};
      vecs[3] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, {16{32'h5555_AAAA}}, {64{8'h5A}}, 1'b1,
                 5, 3, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, '0};
      vecs[4] = '{1'b1, 1'b0, 64'h8000_0000_0000_003F, {16{32'h7E57_DA7A}}, {64{8'hC3}}, 1'b0,
                 5, 3, 64'h8000_0000_0000_0000, 1'b0, {16{32'h7E57_DA7A}}};

      rst_n = 1'b0;
      ic_req_vld_i = 1'b0; ic_req_addr_i = '0; ic_resp_rdy_i = 1'b0;
      dc_req_vld_i = 1'b0; dc_req_rd_i = 1'b0; dc_req_addr_i = '0;
      dc_req_wdata_i = '0; dc_resp_rdy_i = 1'b0;
      cache_req_rdy_i = 1'b0; cache_resp_vld_i = 1'b0;
      cache_resp_rdata_i = '0; cache_resp_err_i = 1'b0;

      repeat (3) @(negedge clk);
      chk_all_zero("in_rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("after_rst");

      // Both requesters held valid for four back-to-back transactions.
      arb_wd = {16{32'h1357_9BDF}};
      ic_req_addr_i  = 64'h0000_0000_4000_0080;
      dc_req_addr_i  = 64'h0000_0000_5000_0100;
      dc_req_rd_i    = 1'b1;
      dc_req_wdata_i = arb_wd;
      ic_req_vld_i   = 1'b1;
      dc_req_vld_i   = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef BIU_ARB_RR_EN
         exp_dc = (k % 2 == 0);
`else
         exp_dc = 1'b1;
`endif
         arb_rd = {16{32'hC0DE_0000 + 32'(k)}};
         #1;
         chk1("arb_gnt_dc", dc_req_rdy_o, exp_dc);
         chk1("arb_gnt_ic", ic_req_rdy_o, !exp_dc);
         e.owner_dc = exp_dc;
         e.rdata    = arb_rd;
         e.err      = 1'b0;
         exp_q.push_back(e);
         @(posedge clk);
         @(negedge clk);
         finish_txn(exp_dc, exp_dc ? 64'h0000_0000_5000_0100 : 64'h0000_0000_4000_0080,
                    1'b1, exp_dc ? arb_wd : '0, arb_rd, 1'b0, 0, 0, 1'b0);
      end
      ic_req_vld_i = 1'b0;
      dc_req_vld_i = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_txn(vecs[i]);

      // Reset while waiting on the BIU response.
      ic_req_addr_i = 64'h0000_0000_3000_0010;
      ic_req_vld_i  = 1'b1;
      #1;
      chk1("rstw_accept", ic_req_rdy_o, 1'b1);
      @(posedge clk);
      @(negedge clk);
      ic_req_vld_i    = 1'b0;
      cache_req_rdy_i = 1'b1;
      @(negedge clk);
      cache_req_rdy_i = 1'b0;
      chk1("rstw_in_wait", cache_resp_rdy_o, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_all_zero("rstw_post");
      cache_resp_vld_i   = 1'b1;
      cache_resp_rdata_i = {64{8'hEE}};
      cache_resp_err_i   = 1'b1;
      @(negedge clk);
      cache_resp_vld_i = 1'b0;
      cache_resp_err_i = 1'b0;
      chk1("late_resp_vld", ic_resp_vld_o | dc_resp_vld_o, 1'b0);
      chkw("late_resp_rdata", ic_resp_rdata_o, '0);
      chk1("late_resp_err", ic_resp_err_o, 1'b0);
      chk1("late_resp_rdy", cache_resp_rdy_o, 1'b0);
      last_ic_rdata = '0;
      run_txn(vecs[0]);

      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
